rtc_hms_counter: RTL



---
 rtl/rtc_pkg.sv | 29 ++
 rtl/rtc_prescaler.sv | 43 ++++
 rtl/rtc_hms_counter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types, limits and the 12 h display helper for the time-of-day counter.
// Used by rtc_prescaler and rtc_hms_counter.
package rtc_pkg;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } rtc_time_t;

    // Returns {pm, hour_12h} for a 24 h hour value.
    function automatic logic [5:0] to12h(input logic [4:0] h24);
        logic       pm;
        logic [4:0] h12;
        pm  = (h24 >= 5'd12);
        h12 = h24;
        if (h24 == 5'd0) begin
            h12 = 5'd12;
        end else if (h24 > 5'd12) begin
            h12 = h24 - 5'd12;
        end
        return {pm, h12};
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV running cycles.
// The count holds while run is low; clear restarts the second.
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int CLK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    // Next count: clear wins, wrap on tick, advance only while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter with prescaled 1 s tick, validated load and 12/24 h display.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_hms_counter
    import rtc_pkg::*;
#(
    parameter int CLK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_i,
    input  logic       mode_12h_i,
    input  logic       load_i,
    input  logic [4:0] load_hh_i,
    input  logic [5:0] load_mm_i,
    input  logic [5:0] load_ss_i,
`ifdef RTC_ALARM_EN
    input  logic       alarm_we_i,
    input  logic [4:0] alarm_hh_i,
    input  logic [5:0] alarm_mm_i,
    input  logic       alarm_on_i,
    input  logic       alarm_ack_i,
    output logic       alarm_o,
`endif
    output logic [5:0] seconds_o,
    output logic [5:0] minutes_o,
    output logic [4:0] hours_o,
    output logic       pm_o,
    output logic       sec_pulse_o,
    output logic       day_pulse_o,
    output logic       load_err_o
);

    rtc_time_t time_q, time_d, time_inc;
    logic      tick, adv, load_ok, load_acc, day_wrap, err_d;
    logic      sec_pulse_q, day_pulse_q, load_err_q;
    logic [5:0] disp12;

    assign load_ok  = (load_hh_i <= HR_MAX) && (load_mm_i <= MIN_MAX)
                   && (load_ss_i <= SEC_MAX);
    assign load_acc = load_i && load_ok;
    assign adv      = tick && !load_acc;

    rtc_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run_i),
        .clear   (load_acc),
        .tick    (tick)
    );

    // Carry chain: time one second ahead of the current value.
    always_comb begin
        time_inc = time_q;
        day_wrap = 1'b0;
        if (time_q.ss == SEC_MAX) begin
            time_inc.ss = '0;
            if (time_q.mm == MIN_MAX) begin
                time_inc.mm = '0;
                if (time_q.hh == HR_MAX) begin
                    time_inc.hh = '0;
                    day_wrap    = 1'b1;
                end else begin
                    time_inc.hh = time_q.hh + 5'd1;
                end
            end else begin
                time_inc.mm = time_q.mm + 6'd1;
            end
        end else begin
            time_inc.ss = time_q.ss + 6'd1;
        end
    end

    // Next time: an accepted load beats the tick of the same cycle.
    always_comb begin
        time_d = time_q;
        if (load_acc) begin
            time_d = '{hh: load_hh_i, mm: load_mm_i, ss: load_ss_i};
        end else if (adv) begin
            time_d = time_inc;
        end
    end

`ifdef RTC_ALARM_EN
    logic [4:0] al_hh_q, al_hh_d;
    logic [5:0] al_mm_q, al_mm_d;
    logic       alarm_q, alarm_d, al_ok, al_hit;

    assign al_ok  = (alarm_hh_i <= HR_MAX) && (alarm_mm_i <= MIN_MAX);
    assign al_hit = adv && (time_inc.hh == al_hh_q)
                 && (time_inc.mm == al_mm_q) && (time_inc.ss == 6'd0);
    assign err_d  = (load_i && !load_ok) || (alarm_we_i && !al_ok);

    // Alarm setpoint write and sticky alarm flag; ack/disable beat a new hit.
    always_comb begin
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        alarm_d = alarm_q;
        if (alarm_we_i && al_ok) begin
            al_hh_d = alarm_hh_i;
            al_mm_d = alarm_mm_i;
        end
        if (alarm_ack_i || !alarm_on_i) begin
            alarm_d = 1'b0;
        end else if (al_hit) begin
            alarm_d = 1'b1;
        end
    end

    // Alarm registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_hh_q <= '0;
            al_mm_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            al_hh_q <= al_hh_d;
            al_mm_q <= al_mm_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;
`else
    assign err_d = load_i && !load_ok;
`endif

    // Time register and registered event pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_q      <= '0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            time_q      <= time_d;
            sec_pulse_q <= adv;
            day_pulse_q <= adv && day_wrap;
            load_err_q  <= err_d;
        end
    end

    assign disp12      = to12h(time_q.hh);
    assign seconds_o   = time_q.ss;
    assign minutes_o   = time_q.mm;
    assign hours_o     = mode_12h_i ? disp12[4:0] : time_q.hh;
    assign pm_o        = disp12[5];
    assign sec_pulse_o = sec_pulse_q;
    assign day_pulse_o = day_pulse_q;
    assign load_err_o  = load_err_q;

endmodule
